// File: rtl/calc_gravity_pkg.sv
// calc_gravity_pkg
// Shared definitions for the frame centre-of-gravity engine:
//   - FSM state encoding (IDLE, DIV, DONE)
//   - default width constants
//   - moment_width(): accumulator width needed so a full frame of
//     maximum-intensity pixels cannot wrap the X/Y moment sums
package calc_gravity_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_X_WIDTH    = 10;
  localparam int DEF_Y_WIDTH    = 10;
  localparam int DEF_MASS_WIDTH = 32;
  localparam int DEF_SUM_WIDTH  = 40;

  // Worst case moment: max weight * max coordinate, summed over every
  // pixel position of a 2^x_w by 2^y_w frame.
  function automatic int moment_width(input int data_w, input int x_w, input int y_w);
    return data_w + x_w + x_w + y_w;
  endfunction

endpackage

// File: rtl/gravity_serial_div.sv
// gravity_serial_div
// Restoring unsigned divider producing one quotient bit per cycle.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   start         load dividend/divisor and begin (ignored state is replaced)
//   dividend      WIDTH-bit numerator
//   divisor       WIDTH-bit denominator
//   busy          high while iterations are running
//   done          high during the final iteration cycle; quotient is valid
//                 from the following cycle until the next start
//   quotient      WIDTH-bit result
//   div_by_zero   divisor captured at start was zero (quotient meaningless)
module gravity_serial_div
  import calc_gravity_pkg::*;
#(
  parameter int WIDTH = DEF_SUM_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvsr;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  // Shift the next dividend bit (MSB of the quotient register, which
  // doubles as the dividend shift register) into the partial remainder
  // and trial-subtract the divisor; the borrow bit decides restore.
  always_comb begin
    rem_sh = {rem, quotient[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvsr};
    done   = busy && (cnt == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem         <= '0;
      dvsr        <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      quotient    <= '0;
      div_by_zero <= 1'b0;
    end else if (start) begin
      rem         <= '0;
      dvsr        <= divisor;
      cnt         <= '0;
      busy        <= 1'b1;
      quotient    <= dividend;
      div_by_zero <= (divisor == '0);
    end else if (busy) begin
      if (!diff[WIDTH]) begin
        rem      <= diff[WIDTH-1:0];
        quotient <= {quotient[WIDTH-2:0], 1'b1};
      end else begin
        rem      <= rem_sh[WIDTH-1:0];
        quotient <= {quotient[WIDTH-2:0], 1'b0};
      end
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/calc_gravity_frame.sv
// calc_gravity_frame
// Frame-level centre-of-gravity engine for the eye-tracker pixel stream.
// Accumulates mass and X/Y first moments of thresholded pixels over a frame,
// then divides at frame end and presents the integer centroid.
// Ports:
//   CCLK, RST     clock and asynchronous active-high reset
//   iVS           frame enable level
//   iDE           pixel valid; each high run is one line
//   iDATA         pixel intensity
//   iTHRESH       weight threshold
//   iMODE         0 = intensity weight, 1 = binary weight
//   oX, oY        centroid (saturated to all-ones if the quotient is too wide)
//   oMASS         total weight of the last delivered frame
//   oEMPTY        last delivered frame had zero mass
//   oVALID        one-cycle pulse when results update
//   oBUSY         division in progress
//   oOVERRUN      one-cycle pulse when a frame end was dropped during division
module calc_gravity_frame
  import calc_gravity_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int X_WIDTH    = DEF_X_WIDTH,
  parameter int Y_WIDTH    = DEF_Y_WIDTH,
  parameter int MASS_WIDTH = DEF_MASS_WIDTH,
  parameter int SUM_WIDTH  = DEF_SUM_WIDTH
) (
  input  logic                  CCLK,
  input  logic                  RST,
  input  logic                  iVS,
  input  logic                  iDE,
  input  logic [DATA_WIDTH-1:0] iDATA,
  input  logic [DATA_WIDTH-1:0] iTHRESH,
  input  logic                  iMODE,
  output logic [X_WIDTH-1:0]    oX,
  output logic [Y_WIDTH-1:0]    oY,
  output logic [MASS_WIDTH-1:0] oMASS,
  output logic                  oEMPTY,
  output logic                  oVALID,
  output logic                  oBUSY,
  output logic                  oOVERRUN
);

  localparam int REQ_SUM_WIDTH = moment_width(DATA_WIDTH, X_WIDTH, Y_WIDTH);
  localparam logic [X_WIDTH-1:0] X_MAX = '1;
  localparam logic [Y_WIDTH-1:0] Y_MAX = '1;

  // Moments wrap by design, but a narrower accumulator than a full frame
  // needs is almost certainly a configuration mistake.
  if (SUM_WIDTH < REQ_SUM_WIDTH) begin : g_sum_width_check
    $warning("calc_gravity_frame: SUM_WIDTH narrower than full-frame moment width");
  end

  logic                  vs_d;
  logic                  de_d;
  logic                  frame_start;
  logic                  frame_end;
  logic                  pixel_ok;
  logic                  de_fall;
  logic [DATA_WIDTH-1:0] weight;
  logic [X_WIDTH-1:0]    x_cnt;
  logic [X_WIDTH-1:0]    x_cur;
  logic [Y_WIDTH-1:0]    y_cnt;
  logic [Y_WIDTH-1:0]    y_cur;
  logic [MASS_WIDTH-1:0] m_acc;
  logic [MASS_WIDTH-1:0] m_base;
  logic [SUM_WIDTH-1:0]  mx_acc;
  logic [SUM_WIDTH-1:0]  mx_base;
  logic [SUM_WIDTH-1:0]  my_acc;
  logic [SUM_WIDTH-1:0]  my_base;

  logic [1:0]            state;
  logic [MASS_WIDTH-1:0] m_shadow;
  logic                  div_start;
  logic                  busy_x, busy_y;
  logic                  done_x, done_y;
  logic                  dbz_x, dbz_y;
  logic [SUM_WIDTH-1:0]  quot_x, quot_y;
  logic [X_WIDTH-1:0]    x_sat;
  logic [Y_WIDTH-1:0]    y_sat;

  // Edge detection, pixel weight, and the "frame start clears first"
  // view of coordinates/sums so a pixel arriving on the start edge is
  // accumulated at (0,0) onto zeroed sums.
  always_comb begin
    frame_start = iVS & ~vs_d;
    frame_end   = ~iVS & vs_d;
    pixel_ok    = iVS & iDE;
    de_fall     = ~iDE & de_d;
    weight      = '0;
    if (iDATA >= iTHRESH) begin
      weight = iMODE ? DATA_WIDTH'(1) : iDATA;
    end
    x_cur   = frame_start ? '0 : x_cnt;
    y_cur   = frame_start ? '0 : y_cnt;
    m_base  = frame_start ? '0 : m_acc;
    mx_base = frame_start ? '0 : mx_acc;
    my_base = frame_start ? '0 : my_acc;
  end

  // Pixel coordinates: x advances per accepted pixel, a line ends on the
  // falling edge of iDE; both saturate rather than wrap.
  always_ff @(posedge CCLK or posedge RST) begin
    if (RST) begin
      vs_d  <= 1'b0;
      de_d  <= 1'b0;
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      vs_d <= iVS;
      de_d <= iDE;
      if (pixel_ok) begin
        x_cnt <= (x_cur == X_MAX) ? X_MAX : x_cur + 1'b1;
        y_cnt <= y_cur;
      end else if (frame_start) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (de_fall) begin
        x_cnt <= '0;
        y_cnt <= (y_cnt == Y_MAX) ? Y_MAX : y_cnt + 1'b1;
      end
    end
  end

  // Live accumulators keep running while a previous frame is being
  // divided; the divider works on its own captured copies.
  always_ff @(posedge CCLK or posedge RST) begin
    if (RST) begin
      m_acc  <= '0;
      mx_acc <= '0;
      my_acc <= '0;
    end else if (pixel_ok) begin
      m_acc  <= m_base + MASS_WIDTH'(weight);
      mx_acc <= mx_base + SUM_WIDTH'(weight) * SUM_WIDTH'(x_cur);
      my_acc <= my_base + SUM_WIDTH'(weight) * SUM_WIDTH'(y_cur);
    end else if (frame_start) begin
      m_acc  <= '0;
      mx_acc <= '0;
      my_acc <= '0;
    end
  end

  // A frame end is only taken when no division is running.
  assign div_start = frame_end && (state != ST_DIV);

  gravity_serial_div #(.WIDTH(SUM_WIDTH)) u_div_x (
    .clk         (CCLK),
    .rst         (RST),
    .start       (div_start),
    .dividend    (mx_acc),
    .divisor     (SUM_WIDTH'(m_acc)),
    .busy        (busy_x),
    .done        (done_x),
    .quotient    (quot_x),
    .div_by_zero (dbz_x)
  );

  gravity_serial_div #(.WIDTH(SUM_WIDTH)) u_div_y (
    .clk         (CCLK),
    .rst         (RST),
    .start       (div_start),
    .dividend    (my_acc),
    .divisor     (SUM_WIDTH'(m_acc)),
    .busy        (busy_y),
    .done        (done_y),
    .quotient    (quot_y),
    .div_by_zero (dbz_y)
  );

  // Both dividers run in lockstep, so either busy flag tracks the DIV state.
  assign oBUSY = busy_x | busy_y;

  // Centroid coordinates saturate when the quotient exceeds the output range.
  always_comb begin
    x_sat = (|quot_x[SUM_WIDTH-1:X_WIDTH]) ? X_MAX : quot_x[X_WIDTH-1:0];
    y_sat = (|quot_y[SUM_WIDTH-1:Y_WIDTH]) ? Y_MAX : quot_y[Y_WIDTH-1:0];
  end

  // Control FSM: capture at frame end, wait out the division, publish the
  // result for one DONE cycle (a frame end there restarts immediately).
  always_ff @(posedge CCLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      m_shadow <= '0;
      oX       <= '0;
      oY       <= '0;
      oMASS    <= '0;
      oEMPTY   <= 1'b0;
      oVALID   <= 1'b0;
      oOVERRUN <= 1'b0;
    end else begin
      oVALID   <= 1'b0;
      oOVERRUN <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (frame_end) begin
            m_shadow <= m_acc;
            state    <= ST_DIV;
          end
        end
        ST_DIV: begin
          if (frame_end) begin
            oOVERRUN <= 1'b1;
          end
          if (done_x && done_y) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          oVALID <= 1'b1;
          oMASS  <= m_shadow;
          if (dbz_x || dbz_y) begin
            oX     <= '0;
            oY     <= '0;
            oEMPTY <= 1'b1;
          end else begin
            oX     <= x_sat;
            oY     <= y_sat;
            oEMPTY <= 1'b0;
          end
          if (frame_end) begin
            m_shadow <= m_acc;
            state    <= ST_DIV;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_gravity_frame.sv
// tb_calc_gravity_frame
// Scoreboard bench: each frame driven pushes its hand-computed centroid,
// mass, empty flag and frame-end cycle; a negedge monitor pops and compares
// whenever oVALID is seen, including the frame-end to valid latency.
module tb_calc_gravity_frame;

  logic        CCLK = 1'b0;
  logic        RST;
  logic        iVS, iDE, iMODE;
  logic [7:0]  iDATA, iTHRESH;
  logic [9:0]  oX, oY;
  logic [31:0] oMASS;
  logic        oEMPTY, oVALID, oBUSY, oOVERRUN;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [31:0] mass;
    logic        empty;
    longint      fe;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  pix [0:3][0:7];
  longint      cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          ovr_cnt = 0;
  longint      fe;

  calc_gravity_frame dut (
    .CCLK     (CCLK),
    .RST      (RST),
    .iVS      (iVS),
    .iDE      (iDE),
    .iDATA    (iDATA),
    .iTHRESH  (iTHRESH),
    .iMODE    (iMODE),
    .oX       (oX),
    .oY       (oY),
    .oMASS    (oMASS),
    .oEMPTY   (oEMPTY),
    .oVALID   (oVALID),
    .oBUSY    (oBUSY),
    .oOVERRUN (oOVERRUN)
  );

  always #5 CCLK = ~CCLK;

  always @(posedge CCLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: compare every presented result against the oldest expectation.
  always @(negedge CCLK) begin
    if (!RST) begin
      if (oOVERRUN) ovr_cnt++;
      if (oVALID) begin
        exp_t e;
        if (sb.size() == 0) begin
          checkOutput("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("oX", oX, e.x);
          checkOutput("oY", oY, e.y);
          checkOutput("oMASS", oMASS, e.mass);
          checkOutput("oEMPTY", oEMPTY, e.empty);
          checkOutput("latency", cyc - e.fe, 41);
        end
      end
    end
  end

  task automatic clearPix();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++)
        pix[r][c] = 8'd0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge CCLK);
      #1;
    end
  endtask

  // Drive one frame from pix[][]; fe returns the cycle of the frame-end edge.
  task automatic applyStimulus(input int w, input int h, input logic mode,
                               input logic [7:0] thresh, output longint fe_out);
    @(posedge CCLK); #1;
    iVS = 1'b1; iDE = 1'b0; iMODE = mode; iTHRESH = thresh; iDATA = 8'd0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        @(posedge CCLK); #1;
        iDE = 1'b1; iDATA = pix[r][c];
      end
      @(posedge CCLK); #1;
      iDE = 1'b0; iDATA = 8'd0;
    end
    @(posedge CCLK); #1;
    iVS = 1'b0;
    fe_out = cyc + 1;
  endtask

  task automatic pushExp(input logic [9:0] x, input logic [9:0] y, input logic [31:0] m,
                         input logic empty, input longint fe_in);
    exp_t e;
    e.x = x; e.y = y; e.mass = m; e.empty = empty; e.fe = fe_in;
    sb.push_back(e);
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge CCLK);
    #1;
    checkOutput("drain_pending", sb.size(), 0);
    idleCycles(2);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_oX"}, oX, 0);
    checkOutput({tag, "_oY"}, oY, 0);
    checkOutput({tag, "_oMASS"}, oMASS, 0);
    checkOutput({tag, "_oEMPTY"}, oEMPTY, 0);
    checkOutput({tag, "_oVALID"}, oVALID, 0);
    checkOutput({tag, "_oBUSY"}, oBUSY, 0);
    checkOutput({tag, "_oOVERRUN"}, oOVERRUN, 0);
  endtask

  initial begin
    RST = 1'b1; iVS = 1'b0; iDE = 1'b0; iDATA = 8'd0; iTHRESH = 8'd0; iMODE = 1'b0;
    clearPix();
    idleCycles(3);
    checkAllZero("reset");
    RST = 1'b0;
    idleCycles(2);

    $display("[TB] single pixel 4x4");
    clearPix(); pix[1][2] = 8'd100;
    applyStimulus(4, 4, 1'b0, 8'd1, fe);
    pushExp(10'd2, 10'd1, 32'd100, 1'b0, fe);
    waitDrain(200);

    $display("[TB] uniform 8x4");
    for (int r = 0; r < 4; r++) for (int c = 0; c < 8; c++) pix[r][c] = 8'd10;
    applyStimulus(8, 4, 1'b0, 8'd0, fe);
    pushExp(10'd3, 10'd1, 32'd320, 1'b0, fe);
    waitDrain(200);

    $display("[TB] binary mode 8x4");
    for (int r = 0; r < 4; r++) for (int c = 0; c < 8; c++) pix[r][c] = 8'd40;
    pix[0][6] = 8'd60; pix[0][7] = 8'd60; pix[3][6] = 8'd60; pix[3][7] = 8'd60;
    applyStimulus(8, 4, 1'b1, 8'd50, fe);
    pushExp(10'd6, 10'd1, 32'd4, 1'b0, fe);
    waitDrain(200);

    $display("[TB] empty frame");
    clearPix();
    applyStimulus(4, 4, 1'b0, 8'd1, fe);
    pushExp(10'd0, 10'd0, 32'd0, 1'b1, fe);
    waitDrain(200);

    $display("[TB] overrun");
    clearPix(); pix[2][3] = 8'd7;
    applyStimulus(4, 4, 1'b0, 8'd1, fe);
    pushExp(10'd3, 10'd2, 32'd7, 1'b0, fe);
    idleCycles(2);
    clearPix(); pix[0][0] = 8'd50;
    applyStimulus(2, 2, 1'b0, 8'd1, fe);
    waitDrain(200);
    checkOutput("overrun_pulses", ovr_cnt, 1);
    clearPix(); pix[1][1] = 8'd9;
    applyStimulus(2, 2, 1'b0, 8'd1, fe);
    pushExp(10'd1, 10'd1, 32'd9, 1'b0, fe);
    waitDrain(200);

    $display("[TB] reset during division");
    clearPix(); pix[1][2] = 8'd100;
    applyStimulus(4, 4, 1'b0, 8'd1, fe);
    idleCycles(10);
    checkOutput("busy_in_div", oBUSY, 1);
    RST = 1'b1;
    #1;
    checkAllZero("midreset");
    idleCycles(2);
    RST = 1'b0;
    idleCycles(2);
    for (int r = 0; r < 4; r++) for (int c = 0; c < 8; c++) pix[r][c] = 8'd10;
    applyStimulus(8, 4, 1'b0, 8'd0, fe);
    pushExp(10'd3, 10'd1, 32'd320, 1'b0, fe);
    waitDrain(200);
    checkOutput("overrun_total", ovr_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_gravity_frame.md
Name: calc_gravity_frame

Overview:
Frame-level centre-of-gravity engine for the eye-tracker pixel stream. It accumulates the mass and the X/Y first moments of thresholded pixel intensities over one frame, using internally generated pixel coordinates. At frame end it latches the sums and runs a bit-serial divider. It then presents the integer centroid (X, Y) and mass to the pupil-tracking logic with a one-cycle valid pulse.

Parameters:
DATA_WIDTH, 8, pixel intensity width
X_WIDTH, 10, column counter / centroid X width (max 2^X_WIDTH columns)
Y_WIDTH, 10, row counter / centroid Y width
MASS_WIDTH, 32, mass accumulator width
SUM_WIDTH, 40, moment accumulator width; divider runs SUM_WIDTH iterations

Ports:
CCLK  input  1  system clock, all logic on rising edge
RST  input  1  asynchronous, active-high reset
iVS  input  1  frame enable level; high for the whole active frame
iDE  input  1  pixel valid; a high run is one line
iDATA  input  DATA_WIDTH  pixel intensity
iTHRESH  input  DATA_WIDTH  weight threshold, sampled every pixel
iMODE  input  1  0 = intensity-weighted, 1 = binary (weight 1)
oX  output  X_WIDTH  centroid column, floor(Mx/M)
oY  output  Y_WIDTH  centroid row, floor(My/M)
oMASS  output  MASS_WIDTH  total weight of last frame
oEMPTY  output  1  last frame had zero mass
oVALID  output  1  one-cycle pulse, result outputs updated
oBUSY  output  1  divider running
oOVERRUN  output  1  one-cycle pulse, frame end dropped while busy

Behaviour:
- Reset: the clock and reset are decided as one clock with an asynchronous, active-high reset. All registers clear to 0. This includes oX, oY, oMASS, oEMPTY, oVALID, oBUSY, oOVERRUN, the counters, the accumulators and the FSM (IDLE).
- Edge detection uses iVS_d, the iVS value registered one cycle earlier.
- Frame start, at the edge where iVS=1 and iVS_d=0:
  - clear the mass and moment accumulators, x and y.
  - A pixel presented in the same cycle is accumulated as (0,0) onto the cleared sums.
- Pixel acceptance: a pixel counts only when iDE=1 and iVS=1.
- Weight w: if iDATA < iTHRESH, w = 0; otherwise w = iDATA (mode 0) or w = 1 (mode 1).
- Accumulation on each accepted pixel:
  - M += w
  - Mx += w*x
  - My += w*y
  - All arithmetic is unsigned and wraps modulo the accumulator width. The defaults cannot overflow for 1024x1024x255.
- Coordinates:
  - x increments per accepted pixel and saturates at 2^X_WIDTH-1.
  - x returns to 0 on the falling edge of iDE (iDE=0 while previously 1); y increments at the same edge.
  - y saturates at 2^Y_WIDTH-1.
- Frame end, at the edge where iVS=0 and iVS_d=1:
  - If the FSM is IDLE or DONE: copy M, Mx, My into divider shadow registers and enter DIV.
  - If the FSM is in DIV: discard the frame, pulse oOVERRUN, and keep the current division.
- FSM:
  - IDLE -> DIV on frame end.
  - DIV: two parallel restoring dividers (Mx/M, My/M), one quotient bit per cycle, SUM_WIDTH cycles. An iteration counter is required.
  - DIV -> DONE after the last iteration.
  - DONE (1 cycle): update the outputs, pulse oVALID; then go to IDLE, or to DIV if a frame end coincides.
  - oBUSY = 1 in DIV.
- Latency: oVALID rises exactly SUM_WIDTH+1 cycles after the frame-end edge.
- Output update in DONE:
  - oX and oY take the low X_WIDTH/Y_WIDTH quotient bits; they saturate to all-ones if higher quotient bits are nonzero.
  - oMASS = shadow M.
  - If M = 0: oX = oY = 0 and oEMPTY = 1, with no division fault. Otherwise oEMPTY = 0.
- Outputs hold between oVALID pulses.
- Accumulation into live accumulators continues during DIV; the next frame is unaffected.

Decomposition:
- Package calc_gravity_pkg holds:
  - the FSM state encoding (IDLE, DIV, DONE);
  - the default width constants;
  - a function giving the moment width required for given X/DATA widths, for parameter checks.
- One sub-module, gravity_serial_div: a parametrised restoring unsigned divider with start/busy/done and a divide-by-zero flag, instantiated twice (X and Y).
- Counters, accumulators and the FSM live in the top module.

Test Plan:
- 4x4 frame, mode 0, thresh 1; single pixel at (x=2, y=1) value 100, rest 0 -> oX=2, oY=1, oMASS=100, oEMPTY=0; oVALID exactly 41 cycles after iVS falls.
- 8x4 frame, all pixels 10, mode 0, thresh 0 -> oMASS=320, oX=3, oY=1.
- 8x4 frame, mode 1, thresh 50; pixels 60 at (6,0),(7,0),(6,3),(7,3), all others 40 -> oMASS=4, oX=6, oY=1.
- All-zero frame, thresh 1 -> oEMPTY=1, oX=0, oY=0, oMASS=0, oVALID pulses.
- Frame-end timing: a 2x2 frame ends 10 cycles after the previous frame end -> oOVERRUN pulses once and the first result is delivered unchanged. A later frame ending after oVALID -> second valid result.
- Assert RST during DIV -> all outputs 0 immediately, FSM IDLE; the next full frame produces a correct result.
